decode_stage: RTL and testbench

Registered, handshaked instruction-decode pipeline stage for the MIPS-subset core. Decodes one 32-bit instruction per cycle into the ALU, GPR, BCE, memory, shifter and PC control bundle, and holds it in an output register with valid/ready flow control. Adds load-use interlocking (parametrised bubble count), illegal-opcode flagging and a saturating stall counter. Sits between fetch and the operand-read/execute stage.

---
 rtl/decode_pkg.sv | 66 ++++++
 rtl/decode_logic.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants, mux encodings and the
// control bundle carried by the decode stage.
package decode_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_COP0    = 6'b010000;
  localparam logic [5:0] OPC_REGIMM  = 6'b000001;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  localparam logic [5:0] FUN_JR   = 6'b001000;
  localparam logic [5:0] FUN_JALR = 6'b001001;

  localparam logic [1:0] GPS_ALU = 2'b00;
  localparam logic [1:0] GPS_MEM = 2'b01;
  localparam logic [1:0] GPS_SHF = 2'b10;
  localparam logic [1:0] GPS_LNK = 2'b11;

  localparam logic [1:0] PCS_J    = 2'b00;
  localparam logic [1:0] PCS_JAL  = 2'b01;
  localparam logic [1:0] PCS_JR   = 2'b10;
  localparam logic [1:0] PCS_JALR = 2'b11;

  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_I = 2'd1,
    CLS_J = 2'd2
  } cls_e;

  typedef struct packed {
    logic [3:0] af;
    logic       imm;
    logic       alu_sel;
    logic       gp_we;
    logic [1:0] gp_sel;
    logic [3:0] bf;
    logic       dm_we;
    logic [2:0] sh;
    logic [1:0] pc_sel;
    logic       is_jump;
    logic       is_branch;
    logic       illegal;
  } ctl_t;

  // Shifts (000xxx minus 001/101), JR/JALR,
  // 100xxx arithmetic/logic and SLT/SLTU.
  function automatic logic fun_legal(
    input logic [5:0] f
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      f[5:3] == 3'b100:   ok = 1'b1;
      f[5:1] == 5'b10101: ok = 1'b1;
      f[5:1] == 5'b00100: ok = 1'b1;
      f[5:3] == 3'b000:
        ok = (f[2:0] != 3'b001) &&
             (f[2:0] != 3'b101);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder: word to
// control bundle, destination and source usage.
module decode_logic
  import decode_pkg::*;
#(
  parameter int GPR_AW = 5
) (
  input  logic [31:0]       instr,
  output ctl_t              ctl,
  output logic [GPR_AW-1:0] cad,
  output logic [GPR_AW-1:0] src_a,
  output logic [GPR_AW-1:0] src_b,
  output logic              use_a,
  output logic              use_b,
  output logic              is_load
);

  logic [5:0] opc;
  logic [5:0] fun;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  cls_e       cls;
  logic       br;
  logic       ld;
  logic       st;
  logic       ialu;
  logic       shf;
  logic       jr;
  logic       jalr;
  logic       unused_shamt;

  assign opc = instr[31:26];
  assign rs  = instr[25:21];
  assign rt  = instr[20:16];
  assign rd  = instr[15:11];
  assign fun = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  assign br   = (opc == OPC_REGIMM) ||
                (opc[5:2] == 4'b0001);
  assign ld   = (opc == OPC_LW);
  assign st   = (opc == OPC_SW);
  assign ialu = (opc[5:3] == 3'b001);
  assign shf  = (fun[5:3] == 3'b000);
  assign jr   = (fun == FUN_JR);
  assign jalr = (fun == FUN_JALR);

  assign src_a   = GPR_AW'(rs);
  assign src_b   = GPR_AW'(rt);
  assign is_load = ld;

  // Instruction class from the major opcode.
  always_comb begin
    cls = CLS_I;
    unique case (1'b1)
      opc == OPC_SPECIAL,
      opc == OPC_COP0: cls = CLS_R;
      opc == OPC_J,
      opc == OPC_JAL:  cls = CLS_J;
      default:         cls = CLS_I;
    endcase
  end

  // Per-class control bundle and source usage.
  always_comb begin
    ctl   = '0;
    cad   = '0;
    use_a = 1'b0;
    use_b = 1'b0;
    unique case (cls)
      CLS_R: begin
        ctl.af      = fun[3:0];
        ctl.alu_sel = 1'b1;
        ctl.illegal = !fun_legal(fun);
        ctl.gp_we   = !ctl.illegal && !jr;
        cad         = GPR_AW'(rd);
        use_a       = 1'b1;
        use_b       = 1'b1;
        if (shf) begin
          ctl.sh     = fun[2:0];
          ctl.gp_sel = GPS_SHF;
        end
        if (jr) begin
          ctl.is_jump = 1'b1;
          ctl.pc_sel  = PCS_JR;
        end
        if (jalr) begin
          ctl.is_jump = 1'b1;
          ctl.pc_sel  = PCS_JALR;
          ctl.gp_sel  = GPS_LNK;
        end
      end
      CLS_J: begin
        ctl.af      = opc[3:0];
        ctl.is_jump = 1'b1;
        ctl.pc_sel  = PCS_J;
        if (opc == OPC_JAL) begin
          cad        = '1;
          ctl.gp_we  = 1'b1;
          ctl.gp_sel = GPS_LNK;
          ctl.pc_sel = PCS_JAL;
        end
      end
      default: begin
        ctl.af      = opc[3:0];
        ctl.imm     = 1'b1;
        ctl.illegal = !(ialu | ld | st | br);
        ctl.gp_we   = ialu | ld;
        ctl.dm_we   = st;
        cad         = GPR_AW'(rt);
        use_a       = ialu | ld | st | br;
        use_b       = st | br;
        if (ld) begin
          ctl.gp_sel = GPS_MEM;
        end
      end
    endcase
    ctl.is_branch = br;
    ctl.bf = (opc == OPC_REGIMM) ?
             {3'b000, rt[0]} : opc[3:0];
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready flow,
// load-use interlock and saturating stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int GPR_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         Af,
  output logic               I,
  output logic               ALU_MUX_SEL,
  output logic [GPR_AW-1:0]  Cad,
  output logic               GP_WE,
  output logic [1:0]         GP_MUX_SEL,
  output logic [3:0]         Bf,
  output logic               DM_WE,
  output logic [2:0]         Shift_Type,
  output logic [1:0]         PC_MUX_Select,
  output logic               is_jump,
  output logic               is_branch,
  output logic               illegal,
  output logic [STALL_W-1:0] stall_cnt
);

  ctl_t              d_ctl;
  ctl_t              q_ctl;
  logic [GPR_AW-1:0] d_cad;
  logic [GPR_AW-1:0] q_cad;
  logic [GPR_AW-1:0] d_a;
  logic [GPR_AW-1:0] d_b;
  logic [GPR_AW-1:0] last_cad;
  logic              d_use_a;
  logic              d_use_b;
  logic              d_load;
  logic              q_load;
  logic [2:0]        bub_cnt;
  logic              hit_q;
  logic              hit_l;
  logic              lu_win;
  logic              haz;
  logic              accept;
  logic              xfer;

  decode_logic #(
    .GPR_AW(GPR_AW)
  ) u_dec (
    .instr   (in_instr),
    .ctl     (d_ctl),
    .cad     (d_cad),
    .src_a   (d_a),
    .src_b   (d_b),
    .use_a   (d_use_a),
    .use_b   (d_use_b),
    .is_load (d_load)
  );

  assign hit_q =
    (d_use_a && d_a != '0 && d_a == q_cad) ||
    (d_use_b && d_b != '0 && d_b == q_cad);
  assign hit_l =
    (d_use_a && d_a != '0 && d_a == last_cad) ||
    (d_use_b && d_b != '0 && d_b == last_cad);

  // The transfer cycle itself is the first
  // bubble, so only counts above one still block.
  assign lu_win = bub_cnt > 3'd1;
  assign haz = (out_valid & q_load & hit_q) |
               (lu_win & hit_l);

  assign in_ready = (!out_valid | out_ready) &
                    !haz & !rst;
  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  // Output register and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q_ctl     <= '0;
      q_cad     <= '0;
      q_load    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q_ctl     <= d_ctl;
      q_cad     <= d_cad;
      q_load    <= d_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Track the last load that left the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bub_cnt  <= '0;
      last_cad <= '0;
    end else if (xfer && q_load &&
                 q_cad != '0) begin
      bub_cnt  <= 3'(LU_BUBBLES);
      last_cad <= q_cad;
    end else if (bub_cnt != '0) begin
      bub_cnt <= bub_cnt - 3'd1;
    end
  end

  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && haz &&
                 stall_cnt != {STALL_W{1'b1}}) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign Af            = q_ctl.af;
  assign I             = q_ctl.imm;
  assign ALU_MUX_SEL   = q_ctl.alu_sel;
  assign Cad           = q_cad;
  assign GP_WE         = q_ctl.gp_we;
  assign GP_MUX_SEL    = q_ctl.gp_sel;
  assign Bf            = q_ctl.bf;
  assign DM_WE         = q_ctl.dm_we;
  assign Shift_Type    = q_ctl.sh;
  assign PC_MUX_Select = q_ctl.pc_sel;
  assign is_jump       = q_ctl.is_jump;
  assign is_branch     = q_ctl.is_branch;
  assign illegal       = q_ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage against a
// rule-level reference model and scoreboard.
module tb_decode_stage;

  localparam int LU   = 1;
  localparam int SMAX = 65535;
  localparam int LU2  = 3;
  localparam int SW2  = 2;
  localparam int SMX2 = (1 << SW2) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  Af, Bf;
  logic        I, ALU_MUX_SEL, GP_WE, DM_WE;
  logic        is_jump, is_branch, illegal;
  logic [4:0]  Cad;
  logic [1:0]  GP_MUX_SEL, PC_MUX_Select;
  logic [2:0]  Shift_Type;
  logic [15:0] stall_cnt;

  logic        rst2, in_valid2, in_ready2;
  logic        out_valid2, out_ready2;
  logic [31:0] in_instr2;
  logic [3:0]  Af2, Bf2;
  logic        I2, AMS2, GPWE2, DMWE2;
  logic        ij2, ib2, il2;
  logic [4:0]  Cad2;
  logic [1:0]  GMS2, PCS2;
  logic [2:0]  ST2;
  logic [SW2-1:0] stall_cnt2;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_instr(in_instr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .Af(Af), .I(I), .ALU_MUX_SEL(ALU_MUX_SEL),
    .Cad(Cad), .GP_WE(GP_WE),
    .GP_MUX_SEL(GP_MUX_SEL), .Bf(Bf),
    .DM_WE(DM_WE), .Shift_Type(Shift_Type),
    .PC_MUX_Select(PC_MUX_Select),
    .is_jump(is_jump), .is_branch(is_branch),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(
    .LU_BUBBLES(LU2), .STALL_W(SW2)
  ) dut2 (
    .clk(clk), .rst(rst2),
    .in_instr(in_instr2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .Af(Af2), .I(I2), .ALU_MUX_SEL(AMS2),
    .Cad(Cad2), .GP_WE(GPWE2),
    .GP_MUX_SEL(GMS2), .Bf(Bf2),
    .DM_WE(DMWE2), .Shift_Type(ST2),
    .PC_MUX_Select(PCS2),
    .is_jump(ij2), .is_branch(ib2),
    .illegal(il2), .stall_cnt(stall_cnt2)
  );

  logic [26:0] dut_b;
  assign dut_b = {Af, I, ALU_MUX_SEL, Cad,
                  GP_WE, GP_MUX_SEL, Bf, DM_WE,
                  Shift_Type, PC_MUX_Select,
                  is_jump, is_branch, illegal};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(
    input logic [5:0] f, input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  // Reference decode from the rule table.
  function automatic logic [26:0] ref_dec(
    input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rt, rd, cad;
    logic [3:0] af, bf;
    logic [2:0] sh;
    logic [1:0] gms, pcs;
    logic r, j, ld, st, br, ia, jr, jalr, ok;
    logic imm, we, dwe, jmp;
    op = w[31:26]; fn = w[5:0];
    rt = w[20:16]; rd = w[15:11];
    r  = (op == 6'd0) || (op == 6'd16);
    j  = (op == 6'd2) || (op == 6'd3);
    ld = (op == 6'd35);
    st = (op == 6'd43);
    br = (op == 6'd1) || (op >= 6'd4 && op <= 6'd7);
    ia = (op >= 6'd8 && op <= 6'd15);
    jr = r && fn == 6'd8;
    jalr = r && fn == 6'd9;
    if (r)
      ok = fn inside {6'd0, 6'd2, 6'd3, 6'd4,
                      6'd6, 6'd7, 6'd8, 6'd9,
                      [6'd32:6'd39], 6'd42, 6'd43};
    else
      ok = j || ia || ld || st || br;
    af  = r ? fn[3:0] : op[3:0];
    imm = !r && !j;
    cad = (op == 6'd3) ? 5'd31 :
          r ? rd : j ? 5'd0 : rt;
    we  = ok && ((r && !jr) || ia || ld ||
                 op == 6'd3);
    gms = ld ? 2'd1 :
          (r && fn < 6'd8) ? 2'd2 :
          (op == 6'd3 || jalr) ? 2'd3 : 2'd0;
    bf  = (op == 6'd1) ? {3'b000, rt[0]} : op[3:0];
    dwe = ok && st;
    sh  = (r && fn < 6'd8) ? fn[2:0] : 3'd0;
    pcs = (op == 6'd3) ? 2'd1 : jr ? 2'd2 :
          jalr ? 2'd3 : 2'd0;
    jmp = j || jr || jalr;
    return {af, imm, r, cad, we, gms, bf, dwe,
            sh, pcs, jmp, br, !ok};
  endfunction

  logic [31:0] mq[$];
  int ready_at[32];
  int cyc = 0;
  int m_stall = 0;
  int n_acc = 0;
  int n_xfer = 0;
  int idle = 0;
  bit last_acc = 0;

  // A source is blocked by a load sitting in the
  // output slot or still inside its bubble window.
  function automatic bit mhaz(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] s[2];
    bit u[2];
    bit r, rd_both, rd_one;
    op = w[31:26];
    s[0] = w[25:21];
    s[1] = w[20:16];
    r = (op == 6'd0) || (op == 6'd16);
    rd_both = r || op == 6'd43 || op == 6'd1 ||
              (op >= 6'd4 && op <= 6'd7);
    rd_one = (op >= 6'd8 && op <= 6'd15) ||
             op == 6'd35;
    u[0] = rd_both || rd_one;
    u[1] = rd_both;
    for (int i = 0; i < 2; i++) begin
      if (u[i] && s[i] != 5'd0) begin
        if (mq.size() != 0 &&
            mq[0][31:26] == 6'd35 &&
            mq[0][20:16] == s[i])
          return 1'b1;
        if (cyc < ready_at[s[i]])
          return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic cycle(input logic v,
                       input logic [31:0] w,
                       input logic r,
                       input logic x);
    bit h, rdy;
    @(negedge clk);
    rst = x; in_valid = v;
    in_instr = w; out_ready = r;
    #1;
    h = mhaz(w);
    rdy = (mq.size() == 0 || r) && !h && !x;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0)
      check("bundle", dut_b, ref_dec(mq[0]));
    check("stall_cnt", stall_cnt, m_stall);
    if (!out_valid) idle++;
    if (out_valid && r && !x) n_xfer++;
    last_acc = 0;
    @(posedge clk);
    if (x) begin
      mq.delete();
      m_stall = 0;
      foreach (ready_at[i]) ready_at[i] = 0;
    end else begin
      if (v && h && m_stall < SMAX) m_stall++;
      if (mq.size() != 0 && r) begin
        if (mq[0][31:26] == 6'd35 &&
            mq[0][20:16] != 5'd0)
          ready_at[mq[0][20:16]] = cyc + LU;
        void'(mq.pop_front());
      end
      if (v && rdy) begin
        mq.push_back(w);
        n_acc++;
        last_acc = 1;
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [31:0] w,
                      output int tries);
    tries = 0;
    do begin
      cycle(1'b1, w, 1'b1, 1'b0);
      tries++;
    end while (!last_acc && tries < 20);
    check("send_acc", last_acc, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] lf[18];
    logic [4:0] a, b, c;
    lf = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7,
           6'd8, 6'd9, 6'd32, 6'd33, 6'd34,
           6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
           6'd42, 6'd43};
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0: return rtype(lf[$urandom_range(0, 17)],
                      a, b, c);
      1: return {6'd16, a, b, c, 5'd0,
                 lf[$urandom_range(0, 17)]};
      2: return itype({3'b001,
                 3'($urandom_range(0, 7))},
                 a, b, 16'($urandom));
      3, 4: return itype(6'd35, a, b, 16'd4);
      5: return itype(6'd43, a, b, 16'd8);
      6: return itype({4'b0001,
                 2'($urandom_range(0, 3))},
                 a, b, 16'd2);
      7: return itype(6'd1, a, b, 16'd3);
      8: return {5'b00001,
                 1'($urandom_range(0, 1)),
                 26'($urandom)};
      9: return $urandom;
      default: return rtype(6'($urandom), a, b, c);
    endcase
  endfunction

  logic [31:0] stream[6];
  logic [31:0] lw5, dep5, addi1, add3;
  int t, t_sum, k;

  initial begin
    rst = 1; in_valid = 0; in_instr = 0;
    out_ready = 0;
    rst2 = 1; in_valid2 = 0; in_instr2 = 0;
    out_ready2 = 0;
    addi1 = itype(6'b001000, 5'd2, 5'd1, 16'd5);
    add3  = rtype(6'b100000, 5'd1, 5'd2, 5'd3);
    lw5   = itype(6'd35, 5'd2, 5'd5, 16'd0);
    dep5  = rtype(6'b100000, 5'd5, 5'd6, 5'd4);
    stream[0] = addi1;
    stream[1] = add3;
    stream[2] = itype(6'd43, 5'd2, 5'd3, 16'd0);
    stream[3] = itype(6'd4, 5'd1, 5'd2, 16'd7);
    stream[4] = {6'd2, 26'h10};
    stream[5] = {6'd3, 26'h20};

    // reset, including a valid input during rst
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, addi1, 1'b1, 1'b1);
    #2;
    check("rst_bundle", dut_b, 27'd0);
    check("rst_stall", stall_cnt, 0);

    // back-to-back stream, JAL fields
    t_sum = 0;
    foreach (stream[i]) begin
      send(stream[i], t);
      t_sum += t;
    end
    check("stream_tries", t_sum, 6);
    #2;
    check("jal_cad", Cad, 5'd31);
    check("jal_gms", GP_MUX_SEL, 2'b11);
    check("jal_pcs", PC_MUX_Select, 2'b01);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // load-use: one bubble
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    send(lw5, t);
    idle = 0;
    send(dep5, t);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("lu_tries", t, 2);
    check("lu_bubble", idle, 1);
    check("lu_stall", stall_cnt, 1);

    // load to $0: no bubble
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    send(itype(6'd35, 5'd2, 5'd0, 16'd0), t);
    idle = 0;
    send(rtype(6'b100000, 5'd0, 5'd6, 5'd4), t);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("lu0_tries", t, 1);
    check("lu0_bubble", idle, 0);
    check("lu0_stall", stall_cnt, 0);

    // back-pressure hold
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    n_xfer = 0;
    send(addi1, t);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, add3, 1'b0, 1'b0);
    cycle(1'b1, add3, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("hold_xfer", n_xfer, 2);

    // illegal opcodes pass through
    send({6'b111111, 26'h155}, t);
    #2;
    check("ill_flag", illegal, 1);
    check("ill_gpwe", GP_WE, 0);
    check("ill_dmwe", DM_WE, 0);
    send(rtype(6'b111111, 5'd1, 5'd2, 5'd3), t);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // reset during a pending load-use stall
    send(lw5, t);
    cycle(1'b1, dep5, 1'b0, 1'b0);
    cycle(1'b1, dep5, 1'b0, 1'b1);
    send(dep5, t);
    check("rst_stall_tries", t, 1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // randomised traffic
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 3) != 0),
            rand_instr(),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 99) == 0));
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // second instance: 3 bubbles, 2-bit counter
    @(negedge clk);
    rst2 = 0; in_valid2 = 1; out_ready2 = 0;
    in_instr2 = itype(6'd35, 5'd2, 5'd7, 16'd0);
    #1;
    check("d2_first_rdy", in_ready2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_instr2 = rtype(6'b100000, 5'd7, 5'd0,
                        5'd1);
      #1;
      check("d2_hold_rdy", in_ready2, 0);
      check("d2_stall", stall_cnt2, i);
    end
    k = 0;
    while (k < 16) begin
      @(negedge clk);
      out_ready2 = 1;
      #1;
      if (in_ready2) break;
      k++;
    end
    check("d2_wait", k, LU2);
    @(negedge clk);
    in_valid2 = 0;
    #1;
    check("d2_sat", stall_cnt2,
          (3 + LU2 > SMX2) ? SMX2 : 3 + LU2);
    check("d2_out", out_valid2, 1);
    check("d2_cad", Cad2, 5'd1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
